// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit holding the HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division, one
// iteration per clock on operand magnitudes, followed by a sign-fix cycle.
// Optional build macro: MDU_EARLY_OUT_EN (multiply stops once the remaining
// multiplier bits are zero; divide by zero skips the iterations).
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | one shift-add / restoring-divide iteration per edge
// FIX   | sign correction and HI/LO write-back, done pulse follows

module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               op_div, sgn_a, sgn_b, div0;
  logic [2*WIDTH-1:0] work;   // product, or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] mcand;  // shifted multiplicand; low half keeps |rs| for divide
  logic [WIDTH-1:0]   opb;    // remaining multiplier bits, or divisor

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     rem_sh, trial;
  logic [2*WIDTH-1:0] mul_sum, prod_s;
  logic [WIDTH-1:0]   rem_u, quot_u, orig_a, hi_res, lo_res;

  // operand magnitudes; unsigned ops (op[0]=1) pass raw values through
  assign a_neg = ~op[0] & rs_val[WIDTH-1];
  assign b_neg = ~op[0] & rt_val[WIDTH-1];
  assign a_mag = a_neg ? -rs_val : rs_val;
  assign b_mag = b_neg ? -rt_val : rt_val;

  assign busy = (state != IDLE);

  // one iteration of each algorithm and the sign-corrected results
  always_comb begin
    rem_sh  = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    trial   = rem_sh - {1'b0, opb};
    mul_sum = opb[0] ? (work + mcand) : work;
    rem_u   = work[2*WIDTH-1:WIDTH];
    quot_u  = work[WIDTH-1:0];
    prod_s  = (sgn_a ^ sgn_b) ? -work : work;
    orig_a  = sgn_a ? -mcand[WIDTH-1:0] : mcand[WIDTH-1:0];
    hi_res  = prod_s[2*WIDTH-1:WIDTH];
    lo_res  = prod_s[WIDTH-1:0];
    if (op_div) begin
      if (div0) begin
        hi_res = orig_a;
        lo_res = '1;
      end else begin
        hi_res = sgn_a ? -rem_u : rem_u;
        lo_res = (sgn_a ^ sgn_b) ? -quot_u : quot_u;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MDU_EARLY_OUT_EN
          if (op[1] && (rt_val == '0)) state_nxt = FIX;
          else                         state_nxt = CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC: begin
        if (cnt == CNT_W'(1)) state_nxt = FIX;
`ifdef MDU_EARLY_OUT_EN
        else if (!op_div && (opb[WIDTH-1:1] == '0)) state_nxt = FIX;
`endif
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture and iteration datapath; counter runs down to 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      op_div <= 1'b0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      div0   <= 1'b0;
      work   <= '0;
      mcand  <= '0;
      opb    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= CNT_W'(WIDTH);
            op_div <= op[1];
            sgn_a  <= a_neg;
            sgn_b  <= b_neg;
            div0   <= op[1] & (rt_val == '0);
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            opb    <= b_mag;
            work   <= op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (op_div) begin
            work <= trial[WIDTH] ? {rem_sh[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
          end else begin
            work  <= mul_sum;
            mcand <= mcand << 1;
            opb   <= opb >> 1;
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO: result write in FIX, MTHI/MTLO only while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      hi <= hi_res;
      lo <= lo_res;
    end else if (state == IDLE) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  // done pulses for the cycle after the FIX edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done <= 1'b0;
    else        done <= (state == FIX);
  end

endmodule
